// File: rtl/lock_pkg.sv
// Shared types and constants for the lock attempt controller.
// The CHANGE state exists only when PW_CHANGE_EN is defined.
package lock_pkg;

    localparam int              PW_W     = 16;
    localparam logic [PW_W-1:0] DEF_PW_C = 16'h01AF;
    localparam int              CNT_W    = 8;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        OPEN   = 2'd1,
        LOCKED = 2'd2
`ifdef PW_CHANGE_EN
        ,
        CHANGE = 2'd3
`endif
    } lock_state_t;

endpackage

// File: rtl/lock_tick_cnt.sv
// Loadable 8-bit down-counter holding the ticks remaining in OPEN or LOCKED.
// Load wins over decrement; the count holds at zero instead of wrapping.
module lock_tick_cnt
    import lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Password-attempt controller: opens on a match, locks out after MAX_FAIL misses.
// Define PW_CHANGE_EN to add the CHANGE state and a writable password register.
module lock_attempt_ctrl
    import lock_pkg::*;
#(
    parameter int              MAX_FAIL = 3,
    parameter int              LOCK_SEC = 30,
    parameter int              OPEN_SEC = 5,
    parameter logic [PW_W-1:0] DEF_PW   = DEF_PW_C
) (
    input  logic            clk_50,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            verify_req,
    input  logic [PW_W-1:0] entry_pw,
    input  logic            chg_req,
    output logic            entry_en,
    output logic            unlock,
    output logic            alarm,
    output logic [2:0]      fail_cnt,
    output logic [7:0]      remain
);

    localparam logic [2:0]       MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [CNT_W-1:0] LOCK_C     = CNT_W'(LOCK_SEC);
    localparam logic [CNT_W-1:0] OPEN_C     = CNT_W'(OPEN_SEC);

    lock_state_t      state_q, state_d;
    logic [2:0]       fail_q, fail_d, fail_inc;
    logic             cnt_load, cnt_dec, cnt_zero, expire;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic [PW_W-1:0]  pw_q;
`ifdef PW_CHANGE_EN
    logic             pw_we;
`endif

    assign fail_inc = (fail_q == MAX_FAIL_C) ? fail_q : fail_q + 3'd1;
    assign expire   = tick && (cnt == CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
`ifdef PW_CHANGE_EN
        pw_we    = 1'b0;
`endif
        case (state_q)
            READY: begin
                if (verify_req) begin
                    if (entry_pw == pw_q) begin
                        state_d  = OPEN;
                        fail_d   = '0;
                        cnt_load = 1'b1;
                        cnt_val  = OPEN_C;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == MAX_FAIL_C) begin
                            state_d  = LOCKED;
                            cnt_load = 1'b1;
                            cnt_val  = LOCK_C;
                        end
                    end
                end
            end
            OPEN: begin
`ifdef PW_CHANGE_EN
                if (chg_req) begin
                    state_d  = CHANGE;
                    cnt_load = 1'b1;
                end else
`endif
                if (cnt_zero) begin
                    state_d = READY;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                    if (expire) state_d = READY;
                end
            end
            LOCKED: begin
                // A drained counter in LOCKED is recovered the same way as a normal expiry.
                if (cnt_zero || expire) begin
                    state_d = READY;
                    fail_d  = '0;
                end
                cnt_dec = tick;
            end
`ifdef PW_CHANGE_EN
            CHANGE: begin
                if (verify_req) begin
                    pw_we   = 1'b1;
                    state_d = READY;
                end
            end
`endif
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
        end
    end

`ifdef PW_CHANGE_EN
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pw_q <= DEF_PW;
        end else if (pw_we) begin
            pw_q <= entry_pw;
        end
    end
`else
    logic unused_chg;
    assign pw_q       = DEF_PW;
    assign unused_chg = chg_req;
`endif

    lock_tick_cnt u_remain (
        .clk        (clk_50),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    assign unlock   = (state_q == OPEN);
    assign alarm    = (state_q == LOCKED);
`ifdef PW_CHANGE_EN
    assign entry_en = (state_q == READY) || (state_q == CHANGE);
`else
    assign entry_en = (state_q == READY);
`endif
    assign fail_cnt = fail_q;
    assign remain   = cnt;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl: directed scenarios then random traffic
// compared against a rule-level model of the lock behaviour.
module tb_lock_attempt_ctrl;
    import lock_pkg::*;

    localparam int MAX_FAIL = 3;
    localparam int LOCK_SEC = 30;
    localparam int OPEN_SEC = 5;
`ifdef PW_CHANGE_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        tick, verify_req, chg_req;
    logic [15:0] entry_pw;
    logic        entry_en, unlock, alarm;
    logic [2:0]  fail_cnt;
    logic [7:0]  remain;

    always #10 clk_50 = ~clk_50;

    lock_attempt_ctrl #(
        .MAX_FAIL (MAX_FAIL),
        .LOCK_SEC (LOCK_SEC),
        .OPEN_SEC (OPEN_SEC),
        .DEF_PW   (16'h01AF)
    ) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .tick       (tick),
        .verify_req (verify_req),
        .entry_pw   (entry_pw),
        .chg_req    (chg_req),
        .entry_en   (entry_en),
        .unlock     (unlock),
        .alarm      (alarm),
        .fail_cnt   (fail_cnt),
        .remain     (remain)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: where the door is, how many misses, how long is left, which password.
    string       m_st;
    int          m_fails;
    int          m_left;
    logic [15:0] m_pw;

    task automatic model_reset();
        m_st    = "READY";
        m_fails = 0;
        m_left  = 0;
        m_pw    = 16'h01AF;
    endtask

    task automatic model_step(input bit t, input bit v, input logic [15:0] pw, input bit c);
        if (m_st == "READY") begin
            if (v) begin
                if (pw == m_pw) begin
                    m_st    = "OPEN";
                    m_fails = 0;
                    m_left  = OPEN_SEC;
                end else begin
                    if (m_fails < MAX_FAIL) m_fails++;
                    if (m_fails == MAX_FAIL) begin
                        m_st   = "LOCKED";
                        m_left = LOCK_SEC;
                    end
                end
            end
        end else if (m_st == "OPEN") begin
            if (CHG_EN && c) begin
                m_st   = "CHANGE";
                m_left = 0;
            end else if (t) begin
                m_left--;
                if (m_left == 0) m_st = "READY";
            end
        end else if (m_st == "LOCKED") begin
            if (t) begin
                m_left--;
                if (m_left == 0) begin
                    m_st    = "READY";
                    m_fails = 0;
                end
            end
        end else if (m_st == "CHANGE") begin
            if (v) begin
                m_pw = pw;
                m_st = "READY";
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/unlock"},   32'(unlock),   32'(m_st == "OPEN"));
        check({tag, "/alarm"},    32'(alarm),    32'(m_st == "LOCKED"));
        check({tag, "/entry_en"}, 32'(entry_en), 32'((m_st == "READY") || (m_st == "CHANGE")));
        check({tag, "/fail_cnt"}, 32'(fail_cnt), 32'(m_fails));
        check({tag, "/remain"},   32'(remain),   32'(m_left));
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks the result.
    task automatic cycle(input bit t, input bit v, input logic [15:0] pw, input bit c, input string tag);
        tick       = t;
        verify_req = v;
        entry_pw   = pw;
        chg_req    = c;
        @(posedge clk_50);
        model_step(t, v, pw, c);
        #1;
        tick       = 1'b0;
        verify_req = 1'b0;
        chg_req    = 1'b0;
        check_outputs(tag);
    endtask

    task automatic tick_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0, tag);
            cycle(1'b0, 1'b0, 16'h0, 1'b0, tag);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tick       = 1'b0;
        verify_req = 1'b0;
        chg_req    = 1'b0;
        entry_pw   = 16'h0;
        model_reset();

        repeat (2) @(posedge clk_50);
        #1;
        check_outputs("reset");
        #4 rst_n = 1'b1;
        @(posedge clk_50);
        #1;
        check_outputs("reset_release");

        // Correct password opens the door for OPEN_SEC ticks.
        cycle(1'b0, 1'b1, 16'h01AF, 1'b0, "open");
        check("open_unlock", 32'(unlock), 32'd1);
        check("open_remain", 32'(remain), 32'd5);
        tick_n(OPEN_SEC, "open_count");
        check("open_done_ready", 32'(entry_en), 32'd1);
        check("open_done_remain", 32'(remain), 32'd0);

        // Two misses, then a match clears the count; a single later miss does not lock.
        cycle(1'b0, 1'b1, 16'h1234, 1'b0, "miss1");
        cycle(1'b0, 1'b1, 16'h1234, 1'b0, "miss2");
        check("two_misses", 32'(fail_cnt), 32'd2);
        cycle(1'b0, 1'b1, 16'h01AF, 1'b0, "match_after_misses");
        check("match_clears", 32'(fail_cnt), 32'd0);
        tick_n(OPEN_SEC, "reopen_count");
        cycle(1'b0, 1'b1, 16'h1234, 1'b0, "miss_again");
        check("miss_again_cnt", 32'(fail_cnt), 32'd1);
        check("miss_again_no_alarm", 32'(alarm), 32'd0);

`ifdef PW_CHANGE_EN
        cycle(1'b0, 1'b1, 16'h01AF, 1'b0, "chg_open");
        cycle(1'b0, 1'b0, 16'h0, 1'b1, "chg_req");
        check("chg_unlock", 32'(unlock), 32'd0);
        check("chg_remain", 32'(remain), 32'd0);
        cycle(1'b0, 1'b1, 16'hBEEF, 1'b0, "chg_write");
        cycle(1'b0, 1'b1, 16'h01AF, 1'b0, "old_pw");
        check("old_pw_fails", 32'(fail_cnt), 32'd1);
        cycle(1'b0, 1'b1, 16'hBEEF, 1'b0, "new_pw");
        check("new_pw_opens", 32'(unlock), 32'd1);
        tick_n(OPEN_SEC, "new_pw_count");
`else
        cycle(1'b0, 1'b1, 16'h01AF, 1'b0, "clear_open");
        tick_n(OPEN_SEC, "clear_count");
`endif

        // Three misses from zero lock the block out.
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b1, 16'h1234, 1'b0, "lock_miss");
            check("lock_miss_cnt", 32'(fail_cnt), 32'(i));
        end
        check("lock_alarm", 32'(alarm), 32'd1);
        check("lock_remain", 32'(remain), 32'd30);
        check("lock_entry_en", 32'(entry_en), 32'd0);

        // Attempts during lockout are ignored, even with the correct password.
        cycle(1'b0, 1'b1, m_pw, 1'b0, "locked_ignore");
        cycle(1'b0, 1'b1, 16'h01AF, 1'b1, "locked_ignore_def");
        check("locked_ignore_cnt", 32'(fail_cnt), 32'd3);
        check("locked_ignore_remain", 32'(remain), 32'd30);
        tick_n(LOCK_SEC, "lock_count");
        check("unlock_fail_clr", 32'(fail_cnt), 32'd0);
        check("unlock_alarm_clr", 32'(alarm), 32'd0);

        // Asynchronous reset in the middle of a lockout.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1234, 1'b0, "relock_miss");
        tick_n(LOCK_SEC - 12, "relock_count");
        check("relock_remain12", 32'(remain), 32'd12);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        check("async_reset_entry_en", 32'(entry_en), 32'd1);
        @(posedge clk_50);
        #5 rst_n = 1'b1;
        @(posedge clk_50);
        #1;
        check_outputs("async_release");
        cycle(1'b0, 1'b1, 16'h01AF, 1'b0, "default_pw_back");
        check("default_pw_opens", 32'(unlock), 32'd1);
        tick_n(OPEN_SEC, "default_pw_count");

        // Random traffic, including tick/verify collisions and stray change requests.
        for (int n = 0; n < 3000; n++) begin
            bit          t, v, c;
            logic [15:0] pw;
            t  = ($urandom_range(3) == 0);
            v  = ($urandom_range(5) == 0);
            c  = ($urandom_range(9) == 0);
            pw = ($urandom_range(1) == 0) ? m_pw : 16'($urandom);
            cycle(t, v, pw, c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
